sdram_port_arbiter: RTL and testbench
=====================================

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 24, SDRAM word address width (16M x16 words).
REQ-002 Parameter DATA_W, default 16, SDRAM data width.
REQ-003 Parameter HOLD_MAX, default 8, maximum consecutive port-0 grants while port 1 or 2 is waiting.
REQ-004 Clock and reset: one clock, clk; reset rstn is asynchronous and active-low.
REQ-005 clk  in  1  system clock.
REQ-006 rstn  in  1  asynchronous active-low reset.
REQ-007 req_valid  in  3  per-port request valid (port 0 = display scanout, port 1 = CPU, port 2 = GPU/SD loader).
REQ-008 req_ready  out  3  per-port request accept, one-hot or zero.
REQ-009 req_write  in  3  per-port 1 = write, 0 = read.
REQ-010 req_addr  in  3*ADDR_W  per-port word address; port n occupies bits [n*ADDR_W +: ADDR_W].
REQ-011 req_wdata  in  3*DATA_W  per-port write data, packed the same way.
REQ-012 resp_valid  out  3  per-port read-data strobe.
REQ-013 resp_rdata  out  DATA_W  read data, shared by all ports.
REQ-014 mem_valid / mem_ready  out / in  1 / 1  command handshake to the SDRAM controller.
REQ-015 mem_write, mem_addr, mem_wdata  out  1, ADDR_W, DATA_W  latched command fields.
REQ-016 mem_rvalid / mem_rdata  in  1 / DATA_W  read return from the controller.
REQ-017 err_rvalid  out  1  sticky flag for an unexpected mem_rvalid.

Function
REQ-018 FSM SHALL have states IDLE, ISSUE and WAIT_RD; at most one transaction is outstanding.
REQ-019 IDLE with any req_valid: SHALL assert req_ready for exactly one winner for one cycle (combinational from state), latch that port's write/addr/wdata and grant index on the edge, then go to ISSUE.
REQ-020 Winner is port 0 if req_valid[0] and (hold_cnt < HOLD_MAX or ports 1 and 2 are idle); otherwise round-robin between ports 1 and 2, starting after rr_last.
REQ-021 hold_cnt SHALL increment on each port-0 grant (saturating at HOLD_MAX) and clear on any port-1 or port-2 grant.
REQ-022 rr_last SHALL update to the granted port on each port-1 or port-2 grant; its reset value is 2, so port 1 wins first.
REQ-023 ISSUE: mem_valid=1 with latched fields held stable until mem_ready. On mem_valid&&mem_ready: write goes to IDLE; read goes to WAIT_RD.
REQ-024 WAIT_RD: on mem_rvalid, the next cycle SHALL have resp_valid[grant]=1 for exactly one cycle and resp_rdata=mem_rdata (registered, 1-cycle latency); the FSM goes to IDLE on that same mem_rvalid edge.
REQ-025 resp_rdata SHALL hold its last value when resp_valid is 0.
REQ-026 mem_rvalid outside WAIT_RD SHALL be ignored for data and SHALL set err_rvalid until reset.
REQ-027 A requester dropping req_valid before req_ready SHALL NOT be granted; no state changes for that port.
REQ-028 New arbitration SHALL NOT occur in ISSUE or WAIT_RD; a simultaneous response and new request are served sequentially (response, then IDLE arbitration).
REQ-029 Throughput: write occupies at least 2 cycles (IDLE, ISSUE); read occupies at least 3 cycles plus controller latency.

Reset
REQ-030 While rstn=0: state IDLE; req_ready, resp_valid, mem_valid, mem_write and err_rvalid = 0; mem_addr, mem_wdata and resp_rdata = 0; hold_cnt = 0; rr_last = 2.
REQ-031 Reset asserted mid-transaction SHALL abort it immediately; no resp_valid is issued afterwards.

Verification
REQ-032 Single read, port 1, addr 0x000123, mem_ready tied 1, mem_rvalid with data 0xBEEF two cycles after accept -> req_ready[1] pulse, mem_valid for 1 cycle, resp_valid[1]=1 with 0xBEEF one cycle after mem_rvalid.
REQ-033 Ports 1 and 2 continuously request writes -> grant order 1,2,1,2; each write takes 2 cycles with mem_ready=1.
REQ-034 Port 0 and port 1 continuously request, HOLD_MAX=8 -> 8 port-0 grants, then 1 port-1 grant, repeating.
REQ-035 mem_ready held 0 for 5 cycles in ISSUE -> mem_valid and fields stable for all 5 cycles, no req_ready pulses.
REQ-036 mem_rvalid pulsed in IDLE -> err_rvalid=1 and held, no resp_valid; rstn low in WAIT_RD -> all outputs 0, later mem_rvalid produces no resp_valid.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// Three-port arbiter in front of a single-outstanding SDRAM controller.
// Port 0 (scanout) has priority bounded by HOLD_MAX; ports 1 and 2 share round-robin.
module sdram_port_arbiter #(
   parameter int ADDR_W   = 24,
   parameter int DATA_W   = 16,
   parameter int HOLD_MAX = 8
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [2:0]            req_valid,
   output logic [2:0]            req_ready,
   input  logic [2:0]            req_write,
   input  logic [3*ADDR_W-1:0]   req_addr,
   input  logic [3*DATA_W-1:0]   req_wdata,
   output logic [2:0]            resp_valid,
   output logic [DATA_W-1:0]     resp_rdata,
   output logic                  mem_valid,
   input  logic                  mem_ready,
   output logic                  mem_write,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic                  mem_rvalid,
   input  logic [DATA_W-1:0]     mem_rdata,
   output logic                  err_rvalid
);

   localparam int HC_W = $clog2(HOLD_MAX + 1);
   localparam logic [HC_W-1:0] HOLD_LIM = HC_W'(HOLD_MAX);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

   state_t            state;
   logic [HC_W-1:0]   hold_cnt;
   logic [1:0]        rr_last;
   logic [1:0]        grant;
   logic [1:0]        win;
   logic              any_win;
   logic              sel_write;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   // Port 0 yields only once it has used up its hold budget while 1 or 2 wait.
   always_comb begin
      win     = 2'd0;
      any_win = 1'b0;
      if (rstn && state == IDLE) begin
         if (req_valid[0] && (hold_cnt < HOLD_LIM || req_valid[2:1] == 2'b00)) begin
            win     = 2'd0;
            any_win = 1'b1;
         end else if (rr_last == 2'd2) begin
            if (req_valid[1]) begin
               win     = 2'd1;
               any_win = 1'b1;
            end else if (req_valid[2]) begin
               win     = 2'd2;
               any_win = 1'b1;
            end
         end else begin
            if (req_valid[2]) begin
               win     = 2'd2;
               any_win = 1'b1;
            end else if (req_valid[1]) begin
               win     = 2'd1;
               any_win = 1'b1;
            end
         end
      end
      req_ready = any_win ? (3'b001 << win) : 3'b000;
   end

   always_comb begin
      sel_write = req_write[0];
      sel_addr  = req_addr[0 +: ADDR_W];
      sel_wdata = req_wdata[0 +: DATA_W];
      case (win)
         2'd1: begin
            sel_write = req_write[1];
            sel_addr  = req_addr[ADDR_W +: ADDR_W];
            sel_wdata = req_wdata[DATA_W +: DATA_W];
         end
         2'd2: begin
            sel_write = req_write[2];
            sel_addr  = req_addr[2*ADDR_W +: ADDR_W];
            sel_wdata = req_wdata[2*DATA_W +: DATA_W];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         grant      <= 2'd0;
         hold_cnt   <= '0;
         rr_last    <= 2'd2;
         mem_valid  <= 1'b0;
         mem_write  <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         resp_valid <= 3'b000;
         resp_rdata <= '0;
         err_rvalid <= 1'b0;
      end else begin
         resp_valid <= 3'b000;
         if (mem_rvalid && state != WAIT_RD) err_rvalid <= 1'b1;
         case (state)
            IDLE: begin
               if (any_win) begin
                  grant     <= win;
                  mem_write <= sel_write;
                  mem_addr  <= sel_addr;
                  mem_wdata <= sel_wdata;
                  mem_valid <= 1'b1;
                  state     <= ISSUE;
                  if (win == 2'd0) begin
                     if (hold_cnt < HOLD_LIM) hold_cnt <= hold_cnt + 1'b1;
                  end else begin
                     hold_cnt <= '0;
                     rr_last  <= win;
                  end
               end
            end
            ISSUE: begin
               if (mem_ready) begin
                  mem_valid <= 1'b0;
                  state     <= mem_write ? IDLE : WAIT_RD;
               end
            end
            WAIT_RD: begin
               // Response is registered; arbitration resumes in the same cycle it appears.
               if (mem_rvalid) begin
                  resp_valid <= 3'b001 << grant;
                  resp_rdata <= mem_rdata;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: grants and read responses are
// predicted into queues as stimulus is applied and compared as the DUT emits them.
module tb_sdram_port_arbiter;

   localparam int ADDR_W   = 24;
   localparam int DATA_W   = 16;
   localparam int HOLD_MAX = 8;

   logic                clk;
   logic                rstn;
   logic [2:0]          req_valid;
   logic [2:0]          req_ready;
   logic [2:0]          req_write;
   logic [3*ADDR_W-1:0] req_addr;
   logic [3*DATA_W-1:0] req_wdata;
   logic [2:0]          resp_valid;
   logic [DATA_W-1:0]   resp_rdata;
   logic                mem_valid;
   logic                mem_ready;
   logic                mem_write;
   logic [ADDR_W-1:0]   mem_addr;
   logic [DATA_W-1:0]   mem_wdata;
   logic                mem_rvalid;
   logic [DATA_W-1:0]   mem_rdata;
   logic                err_rvalid;

   int vectors;
   int miscompares;
   int exp_port_q[$];
   logic [DATA_W-1:0] exp_data_q[$];

   sdram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .HOLD_MAX(HOLD_MAX)) dut (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_write(mem_write),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .err_rvalid(err_rvalid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_reset();
      rstn = 1'b0;
      req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      exp_port_q.delete();
      exp_data_q.delete();
      repeat (2) @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      req_valid = 3'b111; req_write = 3'b111; req_addr = '1; req_wdata = '1;
      mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 16'hFFFF;
      repeat (2) @(negedge clk);
      #1;
      vectors++; if (req_ready !== 3'b000) begin miscompares++; $display("FAIL rst_req_ready: got %0h expected 0", req_ready); end
      vectors++; if (resp_valid !== 3'b000) begin miscompares++; $display("FAIL rst_resp_valid: got %0h expected 0", resp_valid); end
      vectors++; if (mem_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mem_valid: got %0h expected 0", mem_valid); end
      vectors++; if (mem_write !== 1'b0) begin miscompares++; $display("FAIL rst_mem_write: got %0h expected 0", mem_write); end
      vectors++; if (err_rvalid !== 1'b0) begin miscompares++; $display("FAIL rst_err_rvalid: got %0h expected 0", err_rvalid); end
      vectors++; if (mem_addr !== '0) begin miscompares++; $display("FAIL rst_mem_addr: got %0h expected 0", mem_addr); end
      vectors++; if (mem_wdata !== '0) begin miscompares++; $display("FAIL rst_mem_wdata: got %0h expected 0", mem_wdata); end
      vectors++; if (resp_rdata !== '0) begin miscompares++; $display("FAIL rst_resp_rdata: got %0h expected 0", resp_rdata); end
   endtask

   task automatic test_single_read();
      int p;
      logic [DATA_W-1:0] d;
      do_reset();
      mem_ready = 1'b1;
      req_valid = 3'b010; req_write = 3'b000; req_addr[ADDR_W +: ADDR_W] = 24'h000123;
      #1;
      vectors++; if (req_ready !== 3'b010) begin miscompares++; $display("FAIL rd_grant: got %0h expected 2", req_ready); end
      @(negedge clk);
      req_valid = 3'b000;
      #1;
      vectors++; if (mem_valid !== 1'b1) begin miscompares++; $display("FAIL rd_issue_valid: got %0h expected 1", mem_valid); end
      vectors++; if (mem_addr !== 24'h000123) begin miscompares++; $display("FAIL rd_issue_addr: got %0h expected 123", mem_addr); end
      vectors++; if (mem_write !== 1'b0) begin miscompares++; $display("FAIL rd_issue_write: got %0h expected 0", mem_write); end
      @(negedge clk);
      #1;
      vectors++; if (mem_valid !== 1'b0) begin miscompares++; $display("FAIL rd_valid_drop: got %0h expected 0", mem_valid); end
      @(negedge clk);
      mem_rvalid = 1'b1; mem_rdata = 16'hBEEF; req_valid = 3'b100;
      exp_port_q.push_back(1); exp_data_q.push_back(16'hBEEF);
      #1;
      vectors++; if (req_ready !== 3'b000) begin miscompares++; $display("FAIL rd_no_arb_wait: got %0h expected 0", req_ready); end
      vectors++; if (resp_valid !== 3'b000) begin miscompares++; $display("FAIL rd_resp_early: got %0h expected 0", resp_valid); end
      @(negedge clk);
      mem_rvalid = 1'b0; mem_rdata = 16'h0000;
      #1;
      vectors++;
      if (resp_valid === 3'b000 || exp_port_q.size() == 0) begin
         miscompares++; $display("FAIL rd_resp_missing: got %0h expected 2", resp_valid);
      end else begin
         p = exp_port_q.pop_front(); d = exp_data_q.pop_front();
         if (resp_valid !== (3'b001 << p) || resp_rdata !== d) begin
            miscompares++; $display("FAIL rd_resp: got valid %0h data %0h expected valid %0h data %0h", resp_valid, resp_rdata, 3'b001 << p, d);
         end
      end
      vectors++; if (req_ready !== 3'b100) begin miscompares++; $display("FAIL rd_arb_after_resp: got %0h expected 4", req_ready); end
      @(negedge clk);
      req_valid = 3'b000;
      #1;
      vectors++; if (resp_valid !== 3'b000) begin miscompares++; $display("FAIL rd_resp_pulse: got %0h expected 0", resp_valid); end
      vectors++; if (resp_rdata !== 16'hBEEF) begin miscompares++; $display("FAIL rd_rdata_hold: got %0h expected beef", resp_rdata); end
   endtask

   task automatic test_round_robin();
      int grants = 0;
      int last = 1;
      int p;
      logic [ADDR_W-1:0] ea;
      do_reset();
      mem_ready = 1'b1; req_write = 3'b110;
      req_addr[ADDR_W +: ADDR_W] = 24'h111111; req_addr[2*ADDR_W +: ADDR_W] = 24'h222222;
      req_valid = 3'b110;
      for (int i = 0; i < 3; i++) begin exp_port_q.push_back(1); exp_port_q.push_back(2); end
      for (int c = 0; c < 12; c++) begin
         #1;
         if (req_ready !== 3'b000) begin
            grants++;
            vectors++;
            if (exp_port_q.size() == 0) begin
               miscompares++; $display("FAIL rr_extra_grant: got %0h expected none", req_ready);
            end else begin
               p = exp_port_q.pop_front();
               last = p;
               if (req_ready !== (3'b001 << p)) begin miscompares++; $display("FAIL rr_order: got %0h expected %0h", req_ready, 3'b001 << p); end
            end
         end else if (mem_valid === 1'b1) begin
            ea = (last == 1) ? 24'h111111 : 24'h222222;
            vectors++;
            if (mem_addr !== ea || mem_write !== 1'b1) begin miscompares++; $display("FAIL rr_cmd: got addr %0h wr %0h expected addr %0h wr 1", mem_addr, mem_write, ea); end
         end
         @(negedge clk);
      end
      req_valid = 3'b000;
      vectors++; if (grants !== 6) begin miscompares++; $display("FAIL rr_grant_count: got %0d expected 6", grants); end
   endtask

   task automatic test_hold();
      int grants = 0;
      int p;
      do_reset();
      mem_ready = 1'b1; req_write = 3'b011; req_valid = 3'b011;
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < HOLD_MAX; k++) exp_port_q.push_back(0);
         exp_port_q.push_back(1);
      end
      for (int c = 0; c < 2 * 2 * (HOLD_MAX + 1); c++) begin
         #1;
         if (req_ready !== 3'b000) begin
            grants++;
            vectors++;
            if (exp_port_q.size() == 0) begin
               miscompares++; $display("FAIL hold_extra_grant: got %0h expected none", req_ready);
            end else begin
               p = exp_port_q.pop_front();
               if (req_ready !== (3'b001 << p)) begin miscompares++; $display("FAIL hold_order grant %0d: got %0h expected %0h", grants, req_ready, 3'b001 << p); end
            end
         end
         @(negedge clk);
      end
      req_valid = 3'b000;
      vectors++; if (exp_port_q.size() != 0) begin miscompares++; $display("FAIL hold_missing_grants: got %0d left expected 0", exp_port_q.size()); end
   endtask

   task automatic test_stall();
      do_reset();
      mem_ready = 1'b0; req_write = 3'b100;
      req_addr[2*ADDR_W +: ADDR_W] = 24'h0ABCDE; req_wdata[2*DATA_W +: DATA_W] = 16'h5A5A;
      req_valid = 3'b100;
      #1;
      vectors++; if (req_ready !== 3'b100) begin miscompares++; $display("FAIL stall_grant: got %0h expected 4", req_ready); end
      @(negedge clk);
      req_valid = 3'b111;
      for (int c = 0; c < 5; c++) begin
         #1;
         vectors++;
         if (mem_valid !== 1'b1 || mem_addr !== 24'h0ABCDE || mem_wdata !== 16'h5A5A || mem_write !== 1'b1 || req_ready !== 3'b000) begin
            miscompares++;
            $display("FAIL stall_cycle%0d: got v%0h a%0h d%0h w%0h rdy%0h expected v1 aabcde d5a5a w1 rdy0", c, mem_valid, mem_addr, mem_wdata, mem_write, req_ready);
         end
         @(negedge clk);
      end
      mem_ready = 1'b1; req_valid = 3'b000;
      #1;
      vectors++; if (mem_valid !== 1'b1) begin miscompares++; $display("FAIL stall_accept_valid: got %0h expected 1", mem_valid); end
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      vectors++; if (mem_valid !== 1'b0) begin miscompares++; $display("FAIL stall_done: got %0h expected 0", mem_valid); end
   endtask

   task automatic test_err_and_abort();
      do_reset();
      mem_rvalid = 1'b1; mem_rdata = 16'h1111;
      #1;
      vectors++; if (err_rvalid !== 1'b0) begin miscompares++; $display("FAIL err_early: got %0h expected 0", err_rvalid); end
      @(negedge clk);
      mem_rvalid = 1'b0;
      #1;
      vectors++; if (err_rvalid !== 1'b1 || resp_valid !== 3'b000) begin miscompares++; $display("FAIL err_set: got err %0h resp %0h expected err 1 resp 0", err_rvalid, resp_valid); end
      repeat (3) @(negedge clk);
      #1;
      vectors++; if (err_rvalid !== 1'b1 || resp_rdata !== '0) begin miscompares++; $display("FAIL err_sticky: got err %0h data %0h expected err 1 data 0", err_rvalid, resp_rdata); end

      do_reset();
      #1;
      vectors++; if (err_rvalid !== 1'b0) begin miscompares++; $display("FAIL err_clear: got %0h expected 0", err_rvalid); end
      mem_ready = 1'b1; req_write = 3'b000; req_addr[0 +: ADDR_W] = 24'h000003; req_valid = 3'b001;
      #1;
      vectors++; if (req_ready !== 3'b001) begin miscompares++; $display("FAIL abort_grant: got %0h expected 1", req_ready); end
      @(negedge clk);
      req_valid = 3'b000;
      @(negedge clk);
      rstn = 1'b0;
      #1;
      vectors++;
      if (mem_valid !== 1'b0 || resp_valid !== 3'b000 || req_ready !== 3'b000 || mem_addr !== '0 || err_rvalid !== 1'b0) begin
         miscompares++; $display("FAIL abort_outputs: got v%0h r%0h rdy%0h a%0h e%0h expected all 0", mem_valid, resp_valid, req_ready, mem_addr, err_rvalid);
      end
      @(negedge clk);
      rstn = 1'b1; mem_rvalid = 1'b1; mem_rdata = 16'hDEAD;
      @(negedge clk);
      mem_rvalid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         vectors++;
         if (resp_valid !== 3'b000 || resp_rdata !== '0) begin miscompares++; $display("FAIL abort_no_resp%0d: got r%0h d%0h expected r0 d0", c, resp_valid, resp_rdata); end
         @(negedge clk);
      end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      test_reset();
      test_single_read();
      test_round_robin();
      test_hold();
      test_stall();
      test_err_and_abort();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
